// File: rtl/hf_subcarrier_rx_ssp.sv
// HF subcarrier receiver: edge-pair detector on ADC samples, per-frame mode latch with
// guard frames, and an SSP-style serial interface toward the ARM.
module hf_subcarrier_rx_ssp #(
  parameter int ADC_W        = 8,
  parameter int SC_PERIOD    = 16,
  parameter int FRAME_BITS   = 8,
  parameter int EDGE_THR     = 40,
  parameter int DET_PHASE    = 3,
  parameter int GUARD_FRAMES = 2
) (
  input  logic             ck_1356meg,
  input  logic             rst,
  input  logic [ADC_W-1:0] adc_d,
  input  logic [2:0]       mode_req,
  input  logic             ssp_dout,
  output logic             ssp_clk,
  output logic             ssp_frame,
  output logic             ssp_din,
  output logic             pwr_hi_gate,
  output logic             mod_sig_coil,
  output logic             curbit
);

  localparam int N_CNT = SC_PERIOD * FRAME_BITS;
  localparam int CNT_W = $clog2(N_CNT);
  localparam int SUB_W = $clog2(SC_PERIOD);
  localparam int FW    = ADC_W + 3;

  localparam logic [CNT_W-1:0]     CNT_LAST   = CNT_W'(N_CNT - 1);
  localparam logic [CNT_W-1:0]     FRM_ON     = CNT_W'(SC_PERIOD / 2 - 1);
  localparam logic [CNT_W-1:0]     FRM_OFF    = CNT_W'(SC_PERIOD + SC_PERIOD / 2 - 1);
  localparam logic [SUB_W-1:0]     SUB_DET    = SUB_W'(DET_PHASE);
  localparam logic [SUB_W-1:0]     SUB_HALF   = SUB_W'(SC_PERIOD / 2);
  localparam logic signed [FW-1:0] THR_P      = FW'(EDGE_THR);
  localparam logic signed [FW-1:0] THR_N      = -THR_P;
  localparam logic signed [FW-1:0] S_ZERO     = '0;
  localparam logic [3:0]           GUARD_INIT = 4'(GUARD_FRAMES);

  typedef enum logic [1:0] {M_SNIFF, M_LISTEN, M_MOD} mode_e;
  typedef enum logic {ST_GUARD, ST_RUN} state_e;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SUB_W-1:0] sub;
  logic             frame_start;

  logic [ADC_W-1:0] h1_q, h2_q, h3_q, h4_q;
  logic signed [FW-1:0] x0, x1, x3, x4, filt;
  logic signed [FW-1:0] fall_max_q, rise_min_q;

  mode_e  mode_q, mode_d, req_mode;
  state_e state_q;
  logic [3:0] guard_q;
  logic enter_guard, run_next;

  logic curbit_q, sendbit_q, din_q, clk_q, frame_q, mod_q, pwr_q;

  assign sub         = cnt_q[SUB_W-1:0];
  assign frame_start = (cnt_q == '0);
  assign cnt_d       = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);

  // Zero-extend before going signed so the 3*(2^ADC_W-1) swing never overflows.
  assign x0   = $signed({3'b000, adc_d});
  assign x1   = $signed({3'b000, h1_q});
  assign x3   = $signed({3'b000, h3_q});
  assign x4   = $signed({3'b000, h4_q});
  assign filt = ((x4 <<< 1) + x3) - ((x0 <<< 1) + x1);

  always_comb begin
    req_mode = M_SNIFF;
    case (mode_req)
      3'b011:  req_mode = M_LISTEN;
      3'b100:  req_mode = M_MOD;
      default: req_mode = M_SNIFF;
    endcase
  end

  assign mode_d      = frame_start ? req_mode : mode_q;
  assign enter_guard = frame_start && (mode_d == M_LISTEN) && (mode_q != M_LISTEN);
  // Frame-start slot must already see the state this frame will run in.
  assign run_next    = !enter_guard && ((state_q == ST_RUN) || (frame_start && guard_q == '0));

  always_ff @(posedge ck_1356meg) begin
    if (rst) begin
      state_q <= ST_GUARD;
      guard_q <= GUARD_INIT;
    end else begin
      case (state_q)
        ST_GUARD: begin
          if (enter_guard) begin
            guard_q <= GUARD_INIT;
          end else if (frame_start) begin
            if (guard_q != '0) guard_q <= guard_q - 4'd1;
            else               state_q <= ST_RUN;
          end
        end
        default: begin
          if (enter_guard) begin
            state_q <= ST_GUARD;
            guard_q <= GUARD_INIT;
          end
        end
      endcase
    end
  end

  always_ff @(posedge ck_1356meg) begin
    if (rst) begin
      cnt_q      <= '0;
      h1_q       <= '0;
      h2_q       <= '0;
      h3_q       <= '0;
      h4_q       <= '0;
      fall_max_q <= '0;
      rise_min_q <= '0;
      curbit_q   <= 1'b0;
      mode_q     <= M_SNIFF;
      sendbit_q  <= 1'b0;
      din_q      <= 1'b0;
      clk_q      <= 1'b0;
      frame_q    <= 1'b0;
      mod_q      <= 1'b0;
      pwr_q      <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      h1_q   <= adc_d;
      h2_q   <= h1_q;
      h3_q   <= h2_q;
      h4_q   <= h3_q;
      mode_q <= mode_d;

      // Decision cycle drops its own filt sample and restarts the window.
      if (sub == SUB_DET) begin
        curbit_q   <= (fall_max_q > THR_P) && (rise_min_q < THR_N);
        fall_max_q <= '0;
        rise_min_q <= '0;
      end else begin
        if ((filt > S_ZERO) && (filt > fall_max_q)) fall_max_q <= filt;
        if ((filt <= S_ZERO) && (filt < rise_min_q)) rise_min_q <= filt;
      end

      if (sub == '0) sendbit_q <= (mode_d == M_LISTEN) && run_next && curbit_q;
      din_q <= sendbit_q;

      if (sub == '0)           clk_q <= 1'b1;
      else if (sub == SUB_HALF) clk_q <= 1'b0;

      if (cnt_q == FRM_ON)       frame_q <= 1'b1;
      else if (cnt_q == FRM_OFF) frame_q <= 1'b0;

      mod_q <= ssp_dout;

      case (mode_q)
        M_LISTEN: pwr_q <= 1'b1;
        M_MOD:    pwr_q <= ~mod_q;
        default:  pwr_q <= 1'b0;
      endcase
    end
  end

  assign curbit       = curbit_q;
  assign ssp_din      = din_q;
  assign ssp_clk      = clk_q;
  assign ssp_frame    = frame_q;
  assign mod_sig_coil = mod_q;
  assign pwr_hi_gate  = pwr_q;

endmodule

// File: tb/tb_hf_subcarrier_rx_ssp.sv
// Bench: two instances (default and long-frame) driven together, checked every cycle
// against an arithmetic model built from recorded inputs.
module tb_hf_subcarrier_rx_ssp;

  localparam int MAXC = 2048;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] adc = 8'd0;
  logic [2:0] mreq = 3'b000;
  logic       dout = 1'b0;

  logic a_clk, a_frame, a_din, a_pwr, a_mod, a_cur;
  logic b_clk, b_frame, b_din, b_pwr, b_mod, b_cur;

  int n_chk = 0;
  int n_err = 0;
  int k = 0;

  logic [7:0] adc_a [MAXC];
  logic [2:0] mreq_a[MAXC];
  logic       dout_a[MAXC];

  always #5 clk = ~clk;

  hf_subcarrier_rx_ssp dut_a (
    .ck_1356meg(clk), .rst(rst), .adc_d(adc), .mode_req(mreq), .ssp_dout(dout),
    .ssp_clk(a_clk), .ssp_frame(a_frame), .ssp_din(a_din), .pwr_hi_gate(a_pwr),
    .mod_sig_coil(a_mod), .curbit(a_cur)
  );

  hf_subcarrier_rx_ssp #(
    .ADC_W(8), .SC_PERIOD(32), .FRAME_BITS(12), .EDGE_THR(40), .DET_PHASE(0), .GUARD_FRAMES(1)
  ) dut_b (
    .ck_1356meg(clk), .rst(rst), .adc_d(adc), .mode_req(mreq), .ssp_dout(dout),
    .ssp_clk(b_clk), .ssp_frame(b_frame), .ssp_din(b_din), .pwr_hi_gate(b_pwr),
    .mod_sig_coil(b_mod), .curbit(b_cur)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s k=%0d got=%0d exp=%0d", tag, k, obs, exp);
    end
  endtask

  // ---------------- reference model (cycle index kk counts from reset release) ----
  function automatic int av(int i);
    return (i < 0) ? 0 : int'(adc_a[i]);
  endfunction

  function automatic int filt_at(int j);
    return 2 * av(j - 4) + av(j - 3) - 2 * av(j) - av(j - 1);
  endfunction

  // curbit reflects the most recent decision: peaks of filt strictly between decisions.
  function automatic int m_cur(int p, int dp, int thr, int kk);
    int d, lo, mx, mn, fv;
    if (kk - 1 < dp) return 0;
    d  = ((kk - 1 - dp) / p) * p + dp;
    lo = (d - p + 1 < 0) ? 0 : d - p + 1;
    mx = 0;
    mn = 0;
    for (int j = lo; j < d; j++) begin
      fv = filt_at(j);
      if (fv > mx) mx = fv;
      if (fv < mn) mn = fv;
    end
    return (mx > thr && mn < -thr) ? 1 : 0;
  endfunction

  function automatic int dec(logic [2:0] m);
    if (m == 3'b011) return 1;
    if (m == 3'b100) return 2;
    return 0;
  endfunction

  function automatic int fmode(int n, int f);
    return (f < 0) ? 0 : dec(mreq_a[f * n]);
  endfunction

  function automatic int mode_at(int n, int kk);
    return (kk == 0) ? 0 : fmode(n, (kk - 1) / n);
  endfunction

  // Frame f transmits only if listening and at least g+1 frames since the last guard entry.
  function automatic int run_en(int n, int g, int f);
    int ent;
    if (fmode(n, f) != 1) return 0;
    ent = -1;
    for (int i = 0; i <= f; i++)
      if (fmode(n, i) == 1 && fmode(n, i - 1) != 1) ent = i;
    return (f - ent >= g + 1) ? 1 : 0;
  endfunction

  function automatic int m_din(int p, int n, int dp, int g, int thr, int kk);
    int c;
    if (kk < 2) return 0;
    c = ((kk - 2) / p) * p;
    return (run_en(n, g, c / n) == 1) ? m_cur(p, dp, thr, c) : 0;
  endfunction

  function automatic int m_clk(int p, int kk);
    return (kk == 0) ? 0 : (((kk - 1) % p) < p / 2 ? 1 : 0);
  endfunction

  function automatic int m_frame(int p, int n, int kk);
    int c;
    if (kk == 0) return 0;
    c = (kk - 1) % n;
    return (c >= p / 2 - 1 && c < p + p / 2 - 1) ? 1 : 0;
  endfunction

  function automatic int m_mod(int kk);
    return (kk == 0) ? 0 : int'(dout_a[kk - 1]);
  endfunction

  function automatic int m_pwr(int n, int kk);
    int md;
    if (kk == 0) return 0;
    md = mode_at(n, kk - 1);
    if (md == 1) return 1;
    if (md == 2) return (m_mod(kk - 1) == 0) ? 1 : 0;
    return 0;
  endfunction

  task automatic check_all();
    chk("a_clk",   int'(a_clk),   m_clk(16, k));
    chk("a_frame", int'(a_frame), m_frame(16, 128, k));
    chk("a_cur",   int'(a_cur),   m_cur(16, 3, 40, k));
    chk("a_din",   int'(a_din),   m_din(16, 128, 3, 2, 40, k));
    chk("a_mod",   int'(a_mod),   m_mod(k));
    chk("a_pwr",   int'(a_pwr),   m_pwr(128, k));
    chk("b_clk",   int'(b_clk),   m_clk(32, k));
    chk("b_frame", int'(b_frame), m_frame(32, 384, k));
    chk("b_cur",   int'(b_cur),   m_cur(32, 0, 40, k));
    chk("b_din",   int'(b_din),   m_din(32, 384, 0, 1, 40, k));
    chk("b_mod",   int'(b_mod),   m_mod(k));
    chk("b_pwr",   int'(b_pwr),   m_pwr(384, k));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    k = 0;
  endtask

  task automatic step(input logic [7:0] a, input logic [2:0] m, input logic d);
    check_all();
    adc = a;
    mreq = m;
    dout = d;
    adc_a[k]  = a;
    mreq_a[k] = m;
    dout_a[k] = d;
    @(posedge clk);
    #1;
    k++;
  endtask

  function automatic logic [7:0] tog(int i, logic [7:0] hi, logic [7:0] lo);
    return ((i / 8) % 2 == 1) ? lo : hi;
  endfunction

  initial begin
    logic [2:0] rm;
    do_reset();

    // Flat input: no edges, nothing ever sent.
    for (int i = 0; i < 400; i++) step(8'd128, 3'b011, 1'($urandom_range(0, 1)));

    do_reset();
    for (int i = 0; i < 1300; i++) step(tog(i, 8'd200, 8'd50), 3'b011, 1'b0);

    do_reset();
    for (int i = 0; i < 700; i++) step(tog(i, 8'd140, 8'd116), 3'b011, 1'b0);

    do_reset();
    for (int i = 0; i < 700; i++) step(tog(i, 8'd132, 8'd124), 3'b011, 1'b0);

    // Listen -> modulate request mid-frame (cnt=40 of frame 3).
    do_reset();
    for (int i = 0; i < 700; i++)
      step(8'd128, (i < 424) ? 3'b011 : 3'b100, 1'($urandom_range(0, 1)));

    do_reset();
    rm = 3'b011;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 89) == 0) begin
        case ($urandom_range(0, 3))
          0:       rm = 3'b000;
          1:       rm = 3'b011;
          2:       rm = 3'b100;
          default: rm = 3'($urandom_range(0, 7));
        endcase
      end
      step(8'(int'(tog(i, 8'd180, 8'd60)) + $urandom_range(0, 40)), rm,
           1'($urandom_range(0, 1)));
    end

    // Reset asserted mid-frame at cnt=200.
    do_reset();
    for (int i = 0; i < 200; i++) step(tog(i, 8'd200, 8'd50), 3'b011, 1'($urandom_range(0, 1)));
    check_all();
    do_reset();
    for (int i = 0; i < 300; i++) step(tog(i, 8'd200, 8'd50), 3'b011, 1'($urandom_range(0, 1)));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/hf_subcarrier_rx_ssp.md
HF_SUBCARRIER_RX_SSP -- requirements
Module: hf_subcarrier_rx_ssp

Interface
REQ-001 SHALL have parameter ADC_W, default 8, ADC sample width (6..10).
REQ-002 SHALL have parameter SC_PERIOD, default 16, carrier cycles per subcarrier bit slot (power of 2, 8..64).
REQ-003 SHALL have parameter FRAME_BITS, default 8, bits per SSP frame (2..16).
REQ-004 SHALL have parameter EDGE_THR, default 40, edge-detect magnitude threshold (unsigned, < 2^(ADC_W+1)).
REQ-005 SHALL have parameter DET_PHASE, default 3, slot phase at which the detector decides and clears (0..SC_PERIOD-1).
REQ-006 SHALL have parameter GUARD_FRAMES, default 2, frames forced to 0 after entering READER_LISTEN (0..15).
REQ-007 SHALL have port ck_1356meg, input, 1 bit: the single carrier clock; all state updates on its rising edge.
REQ-008 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-009 SHALL have port adc_d, input, ADC_W bits: unsigned ADC sample.
REQ-010 SHALL have port mode_req, input, 3 bits: requested mode (000 SNIFFER, 011 READER_LISTEN, 100 READER_MOD; other codes are treated as SNIFFER).
REQ-011 SHALL have port ssp_dout, input, 1 bit: ARM modulation bit.
REQ-012 SHALL have output ssp_clk, 1 bit; ssp_frame, 1 bit; ssp_din, 1 bit; pwr_hi_gate, 1 bit (carrier enable); mod_sig_coil, 1 bit; curbit, 1 bit (debug). All outputs SHALL be registered.

Function
REQ-013 cnt SHALL count 0..SC_PERIOD*FRAME_BITS-1 and wrap to 0. Define sub = cnt mod SC_PERIOD and slot = cnt / SC_PERIOD.
REQ-014 A 4-deep sample history h1..h4 SHALL shift every cycle (h1 <= adc_d).
REQ-015 filt SHALL equal (2*h4 + h3) - (2*adc_d + h1), computed signed at ADC_W+3 bits with no overflow.
REQ-016 At sub==DET_PHASE the detector SHALL:
- set curbit <= (fall_max > EDGE_THR) && (rise_min < -EDGE_THR);
- clear fall_max and rise_min to 0;
- discard that cycle's filt.
REQ-017 On other cycles the detector SHALL update on filt only:
- filt > 0 and filt > fall_max: fall_max <= filt;
- filt <= 0 and filt < rise_min: rise_min <= filt.
REQ-018 mode_req SHALL be sampled into mode_act only at cnt==0, so a mode change never takes effect mid-frame.
REQ-019 A two-state FSM SHALL run:
- GUARD: entered on reset, or at cnt==0 when mode_act changes to READER_LISTEN; loads guard_cnt = GUARD_FRAMES.
- GUARD: at each cnt==0 with guard_cnt != 0, decrement guard_cnt; at cnt==0 with guard_cnt==0, go to RUN.
- RUN: go to GUARD when mode_act changes to READER_LISTEN.
REQ-020 At sub==0, sendbit SHALL become curbit if mode_act==READER_LISTEN and the FSM is in RUN, else 0. ssp_din SHALL equal sendbit one cycle later.
REQ-021 ssp_clk SHALL go high at sub==0 and low at sub==SC_PERIOD/2, each taking effect one cycle after the decode.
REQ-022 ssp_frame SHALL go high at cnt==SC_PERIOD/2-1 and low at cnt==SC_PERIOD+SC_PERIOD/2-1 (registered).
REQ-023 mod_sig_coil SHALL equal ssp_dout delayed by 1 cycle.
REQ-024 pwr_hi_gate SHALL be registered as:
- 1 when mode_act==READER_LISTEN;
- ~mod_sig_coil when mode_act==READER_MOD;
- 0 otherwise.
REQ-025 When a mode_act update (cnt==0) and a detector decision (sub==DET_PHASE==0) fall in the same cycle, both SHALL take effect; the detector is unaffected by mode.

Reset
REQ-026 On rst=1 the block SHALL set:
- cnt=0; history, fall_max, rise_min = 0;
- curbit, sendbit, ssp_din, ssp_clk, ssp_frame, mod_sig_coil, pwr_hi_gate = 0;
- mode_act = SNIFFER; FSM = GUARD with guard_cnt = GUARD_FRAMES.
REQ-027 Reset asserted mid-frame SHALL take effect at the next rising edge; the first cycle after release SHALL have cnt=0.

Verification
REQ-028 Defaults; adc_d=128 constant; mode_req=011 -> ssp_din=0 throughout; ssp_clk period 16; ssp_frame high 16 cycles, once per 128 cycles.
REQ-029 Defaults; READER_LISTEN; adc_d toggles 200/50 every 8 cycles -> ssp_din=0 for frames 0..2 (mode latch plus 2 guard frames), then 1 in every slot.
REQ-030 Same as REQ-029 with amplitude 140/116 (|filt| max 72 > 40) -> curbit=1; with amplitude 132/124 (|filt| max 24) -> curbit=0.
REQ-031 mode_req changes 011->100 at cnt=40 -> pwr_hi_gate stays 1 until the cnt==0 update; then pwr_hi_gate = ~ssp_dout delayed 2 cycles.
REQ-032 SC_PERIOD=32, FRAME_BITS=12 -> cnt wraps at 383; ssp_frame high from cnt 15 to 47; reset asserted at cnt=200 -> all outputs 0 on the next cycle.
